cnn_stream_core: RTL and testbench
==================================

# cnn_stream_core

Parametrised streaming 3x3 convolution engine. It succeeds the single-channel, fixed-width CNN datapath. It consumes an unsigned pixel stream over ready/valid and produces NUM_CH output channels in parallel. Per channel it applies a requantising shift, optional ReLU, signed saturation and an optional real 2x2/stride-2 max-pool. It sits between the accelerator's OBI DMA/register front-end and memory write-back; that front-end drives the cfg, weight and stream ports.

## Interface
- DATA_WIDTH, 8: pixel width (unsigned in), weight and output width (signed).
- MAX_W, 28: maximum image width; sizes the line buffers and the pool buffer.
- NUM_CH, 2: output channels, each with an independent 3x3 kernel.
- ACC_WIDTH, 32: signed accumulator width.
- DIM_W, $clog2(MAX_W+1): width of the dimension fields.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cfg_width_i  in  DIM_W  image width W.
- cfg_height_i  in  16  image height H.
- cfg_shift_i  in  5  arithmetic right shift applied to the accumulator.
- cfg_relu_en_i  in  1  ReLU enable.
- cfg_pool_en_i  in  1  2x2 max-pool enable.
- start_i  in  1  start a frame; sampled in IDLE only.
- busy_o  out  1  high from an accepted start until done.
- done_o  out  1  one-cycle pulse at frame end.
- err_o  out  1  one-cycle pulse when start is rejected.
- wt_we_i  in  1  weight write strobe.
- wt_ch_i  in  $clog2(NUM_CH)  channel to write.
- wt_idx_i  in  4  tap index 0..8, row-major, where 0 is top-left.
- wt_data_i  in  DATA_WIDTH  signed weight.
- in_valid_i / in_ready_o  in / out  1  pixel handshake.
- in_data_i  in  DATA_WIDTH  pixel, raster order.
- out_valid_o / out_ready_i  out / in  1  result handshake.
- out_data_o  out  NUM_CH*DATA_WIDTH  channel k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_last_o  out  1  marks the final result of the frame.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i, the block checks the configuration.
  - Valid configuration (3<=W<=MAX_W, H>=3, and with pool enabled also W>=4, H>=4): latch all cfg_* inputs, clear the row/col counters, go to RUN.
  - Invalid configuration: pulse err_o and stay in IDLE.
- Weights:
  - Written in IDLE only; writes while busy are ignored, as are writes with wt_idx_i>8 or an out-of-range channel.
  - Weights reset to 0.
- RUN:
  - Each accepted pixel shifts into two row line buffers and the 3x3 window.
  - col counts 0..W-1; row increments when col wraps.
  - A window is complete when the pixel just accepted has row>=2 and col>=2.
  - The conv output coordinate is (r,c) = (row-2, col-2).
- Per-channel arithmetic:
  - acc = sum of unsigned pixel times signed weight, computed in ACC_WIDTH.
  - Then: arithmetic shift right by the latched shift; then, if ReLU is enabled, negative values become 0; then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output without pool: every complete window produces a result.
- Output with pool:
  - Valid region: Wc=W-2, Hc=H-2; only r < 2*floor(Hc/2) and c < 2*floor(Wc/2) are used.
  - Even c: hold the value in an hmax register.
  - Odd c on even r: write max(hmax, value) to the pool buffer at index c/2.
  - Odd c on odd r: emit max(poolbuf[c/2], hmax, value).
  - Odd trailing rows and columns are discarded.
- out_last_o is asserted with the final result: conv (Hc-1, Wc-1) without pool, or pool result (Hc/2-1, Wc/2-1) with pool.
- After the last pixel (row H-1, col W-1) is accepted: go to DRAIN. Leave DRAIN when out_valid_o is 0 or drains this cycle, then enter DONE.
- DONE: pulse done_o for one cycle, then return to IDLE.

## Timing
- All outputs and state reset to 0 / IDLE. Reset mid-frame aborts the frame with no done_o; the line buffers need not be cleared.
- in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
- Latency: the result is registered and out_valid_o rises the cycle after the completing pixel is accepted.
- out_data_o and out_last_o are held stable while out_valid_o && !out_ready_i.
- Back-to-back accept and drain in the same cycle is allowed; full throughput is 1 pixel/cycle.
- Pixels presented outside RUN are not accepted.
- busy_o = (state!=IDLE).
- done_o asserts the cycle after the last result handshake, or the cycle after the last pixel if no result is pending.
- start_i is ignored unless the FSM is in IDLE.
- cfg_* inputs may change freely while busy.

## Test plan
- Identity kernel (tap 4 = 1) on ch0, ch1 = tap 4 = -1. 4x4 image of pixels 0..15, shift 0, ReLU/pool off. Required ch0 = 5,6,9,10 and ch1 = -5,-6,-9,-10, with out_last_o on the 4th result; then done_o.
- Same frame with ReLU on: ch1 all 0. Pool on: a single result, ch0=10, with out_last_o.
- All weights 127, pixels 255, shift 0: output 127 (saturated). All weights -128, ReLU off: output -128. Shift 16 with all weights 127: 4.
- 5x5 with pool on: Hc=Wc=3, so exactly 1 result, taken from conv (0..1, 0..1); trailing conv row and column dropped.
- Hold out_ready_i low for 5 cycles mid-frame on a 28x28 image: in_ready_o is low throughout. Exactly 676 results arrive in order with no loss or duplication.
- start with W=2, or W=MAX_W+1, or pool on with H=3: err_o pulses, busy_o stays 0. Weight write while busy: old weight kept. Reset mid-frame: busy_o=0 and a new frame runs correctly.

Source files
------------

// File: rtl/cnn_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_core
// Brief    : Streaming 3x3 convolution, NUM_CH channels, requant/ReLU/saturate
//            with optional 2x2 stride-2 max-pool.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_stream_core #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_W      = 28,
  parameter int NUM_CH     = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int DIM_W      = $clog2(MAX_W + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [DIM_W-1:0]                           cfg_width_i,
  input  logic [15:0]                                cfg_height_i,
  input  logic [4:0]                                 cfg_shift_i,
  input  logic                                       cfg_relu_en_i,
  input  logic                                       cfg_pool_en_i,
  input  logic                                       start_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o,
  input  logic                                       wt_we_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wt_ch_i,
  input  logic [3:0]                                 wt_idx_i,
  input  logic [DATA_WIDTH-1:0]                      wt_data_i,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]                      in_data_i,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0]               out_data_o,
  output logic                                       out_last_o
);

  localparam int c_lb_aw = $clog2(MAX_W);
  localparam int c_pb_aw = $clog2(MAX_W / 2);
  localparam int c_pb_n  = MAX_W / 2;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic signed [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  logic [1:0]                   r_state;
  logic [DIM_W-1:0]             r_width, r_col;
  logic [15:0]                  r_height, r_row;
  logic [4:0]                   r_shift;
  logic                         r_relu, r_pool, r_err;
  logic                         r_out_valid, r_out_last;
  logic [NUM_CH*DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0]        r_wt  [NUM_CH][9];
  logic [DATA_WIDTH-1:0]        r_lb1 [MAX_W];
  logic [DATA_WIDTH-1:0]        r_lb2 [MAX_W];
  logic [DATA_WIDTH-1:0]        r_wa  [3];
  logic [DATA_WIDTH-1:0]        r_wb  [3];

  logic [DATA_WIDTH-1:0]        w_newcol [3];
  logic [DATA_WIDTH-1:0]        w_pix    [9];
  logic [NUM_CH*DATA_WIDTH-1:0] w_res_all;
  logic                         w_cfg_ok, w_accept, w_col_last, w_row_last, w_win_ok;
  logic                         w_in_pool, w_emit, w_last, w_pool_upd;
  logic [15:0]                  w_r, w_hlim;
  logic [DIM_W-1:0]             w_c, w_wlim;

  assign w_cfg_ok = (cfg_width_i >= DIM_W'(3)) && (cfg_width_i <= DIM_W'(MAX_W)) &&
                    (cfg_height_i >= 16'd3) &&
                    (!cfg_pool_en_i || ((cfg_width_i >= DIM_W'(4)) && (cfg_height_i >= 16'd4)));

  assign in_ready_o = (r_state == c_st_run) && (!r_out_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_col_last = (r_col == r_width - DIM_W'(1));
  assign w_row_last = (r_row == r_height - 16'd1);
  assign w_win_ok   = (r_row >= 16'd2) && (r_col >= DIM_W'(2));

  // Conv coordinate of the window completed by the pixel being accepted.
  assign w_r        = r_row - 16'd2;
  assign w_c        = r_col - DIM_W'(2);
  assign w_hlim     = (r_height - 16'd2) & ~16'd1;
  assign w_wlim     = (r_width - DIM_W'(2)) & ~DIM_W'(1);
  assign w_in_pool  = (w_r < w_hlim) && (w_c < w_wlim);
  assign w_emit     = w_win_ok && (!r_pool || (w_in_pool && w_c[0] && w_r[0]));
  assign w_last     = r_pool ? ((w_r == w_hlim - 16'd1) && (w_c == w_wlim - DIM_W'(1)))
                             : (w_row_last && w_col_last);
  assign w_pool_upd = w_accept && w_win_ok && r_pool && w_in_pool;

  always_comb begin
    w_newcol[0] = r_lb2[r_col[c_lb_aw-1:0]];
    w_newcol[1] = r_lb1[r_col[c_lb_aw-1:0]];
    w_newcol[2] = in_data_i;
    for (int rr = 0; rr < 3; rr++) begin
      w_pix[rr*3 + 0] = r_wa[rr];
      w_pix[rr*3 + 1] = r_wb[rr];
      w_pix[rr*3 + 2] = w_newcol[rr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb2[r_col[c_lb_aw-1:0]] <= r_lb1[r_col[c_lb_aw-1:0]];
      r_lb1[r_col[c_lb_aw-1:0]] <= in_data_i;
      for (int rr = 0; rr < 3; rr++) begin
        r_wa[rr] <= r_wb[rr];
        r_wb[rr] <= w_newcol[rr];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic signed [ACC_WIDTH-1:0]  w_acc, w_sh;
      logic signed [DATA_WIDTH-1:0] w_sat, w_hm, w_res;
      logic signed [DATA_WIDTH-1:0] r_hmax;
      logic signed [DATA_WIDTH-1:0] r_pbuf [c_pb_n];

      always_comb begin
        w_acc = '0;
        for (int t = 0; t < 9; t++) begin
          w_acc = w_acc + $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_pix[t]}) *
                          $signed({{(ACC_WIDTH-DATA_WIDTH){r_wt[g][t][DATA_WIDTH-1]}}, r_wt[g][t]});
        end
        w_sh = w_acc >>> r_shift;
        if (r_relu && (w_sh < 0)) w_sh = '0;
        if (w_sh > c_sat_max)      w_sat = c_sat_max[DATA_WIDTH-1:0];
        else if (w_sh < c_sat_min) w_sat = c_sat_min[DATA_WIDTH-1:0];
        else                       w_sat = w_sh[DATA_WIDTH-1:0];
        w_hm  = (r_pbuf[w_c[c_pb_aw:1]] > r_hmax) ? r_pbuf[w_c[c_pb_aw:1]] : r_hmax;
        w_res = r_pool ? ((w_hm > w_sat) ? w_hm : w_sat) : w_sat;
      end

      // Even columns park their value; odd columns fold it into the row-pair maximum.
      always_ff @(posedge clk_i) begin
        if (w_pool_upd) begin
          if (!w_c[0])      r_hmax <= w_sat;
          else if (!w_r[0]) r_pbuf[w_c[c_pb_aw:1]] <= (r_hmax > w_sat) ? r_hmax : w_sat;
        end
      end

      assign w_res_all[g*DATA_WIDTH +: DATA_WIDTH] = w_res;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= c_st_idle;
      r_width     <= '0;
      r_height    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_pool      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++)
        for (int t = 0; t < 9; t++)
          r_wt[ch][t] <= '0;
    end else begin
      r_err <= 1'b0;
      if (wt_we_i && (r_state == c_st_idle) && (wt_idx_i <= 4'd8) && (32'(wt_ch_i) < NUM_CH))
        r_wt[wt_ch_i][wt_idx_i] <= wt_data_i;

      case (r_state)
        c_st_idle: begin
          if (start_i) begin
            if (w_cfg_ok) begin
              r_width  <= cfg_width_i;
              r_height <= cfg_height_i;
              r_shift  <= cfg_shift_i;
              r_relu   <= cfg_relu_en_i;
              r_pool   <= cfg_pool_en_i;
              r_col    <= '0;
              r_row    <= '0;
              r_state  <= c_st_run;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        c_st_run: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + 16'd1;
            end else begin
              r_col <= r_col + DIM_W'(1);
            end
            if (w_row_last && w_col_last) r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          if (!r_out_valid || out_ready_i) r_state <= c_st_done;
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase

      if (w_accept && w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res_all;
        r_out_last  <= w_last;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy_o      = (r_state != c_st_idle);
  assign done_o      = (r_state == c_st_done);
  assign err_o       = r_err;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_cnn_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_stream_core
// Brief    : Self-checking bench for cnn_stream_core against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_stream_core;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  cfg_width_i;
  logic [15:0] cfg_height_i;
  logic [4:0]  cfg_shift_i;
  logic        cfg_relu_en_i, cfg_pool_en_i, start_i;
  logic        busy_o, done_o, err_o;
  logic        wt_we_i;
  logic [0:0]  wt_ch_i;
  logic [3:0]  wt_idx_i;
  logic [7:0]  wt_data_i;
  logic        in_valid_i, in_ready_o;
  logic [7:0]  in_data_i;
  logic        out_valid_o, out_ready_i, out_last_o;
  logic [15:0] out_data_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          img [784];
  int          wts [2][9];
  logic [15:0] exp_d [$];
  bit          exp_l [$];
  logic [15:0] got_d [$];
  bit          got_l [$];

  always #5 clk = ~clk;

  cnn_stream_core #(
    .DATA_WIDTH (8),
    .MAX_W      (28),
    .NUM_CH     (2),
    .ACC_WIDTH  (32),
    .DIM_W      (5)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cfg_width_i   (cfg_width_i),
    .cfg_height_i  (cfg_height_i),
    .cfg_shift_i   (cfg_shift_i),
    .cfg_relu_en_i (cfg_relu_en_i),
    .cfg_pool_en_i (cfg_pool_en_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .wt_we_i       (wt_we_i),
    .wt_ch_i       (wt_ch_i),
    .wt_idx_i      (wt_idx_i),
    .wt_data_i     (wt_data_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_last_o    (out_last_o)
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Whole-frame reference: full conv map first, then optional pooling over it.
  task automatic build_model(input int w, input int h, input int sh, input bit relu, input bit pool);
    int conv [2][26][26];
    int acc, v, a0, a1;
    exp_d.delete();
    exp_l.delete();
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < h - 2; r++)
        for (int c = 0; c < w - 2; c++) begin
          acc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += img[(r + i) * w + c + j] * wts[ch][i * 3 + j];
          v = acc >>> sh;
          if (relu && v < 0) v = 0;
          if (v > 127) v = 127;
          if (v < -128) v = -128;
          conv[ch][r][c] = v;
        end
    if (!pool) begin
      for (int r = 0; r < h - 2; r++)
        for (int c = 0; c < w - 2; c++) begin
          a0 = conv[0][r][c];
          a1 = conv[1][r][c];
          exp_d.push_back({8'(a1), 8'(a0)});
          exp_l.push_back((r == h - 3) && (c == w - 3));
        end
    end else begin
      for (int pr = 0; pr < (h - 2) / 2; pr++)
        for (int pc = 0; pc < (w - 2) / 2; pc++) begin
          a0 = imax(imax(conv[0][2*pr][2*pc], conv[0][2*pr][2*pc+1]),
                    imax(conv[0][2*pr+1][2*pc], conv[0][2*pr+1][2*pc+1]));
          a1 = imax(imax(conv[1][2*pr][2*pc], conv[1][2*pr][2*pc+1]),
                    imax(conv[1][2*pr+1][2*pc], conv[1][2*pr+1][2*pc+1]));
          exp_d.push_back({8'(a1), 8'(a0)});
          exp_l.push_back((pr == (h - 2) / 2 - 1) && (pc == (w - 2) / 2 - 1));
        end
    end
  endtask

  task automatic load_weights();
    for (int ch = 0; ch < 2; ch++)
      for (int t = 0; t < 9; t++) begin
        @(negedge clk);
        wt_we_i   = 1'b1;
        wt_ch_i   = 1'(ch);
        wt_idx_i  = 4'(t);
        wt_data_i = 8'(wts[ch][t]);
      end
    @(negedge clk);
    wt_we_i = 1'b0;
  endtask

  task automatic rand_weights();
    for (int ch = 0; ch < 2; ch++)
      for (int t = 0; t < 9; t++)
        wts[ch][t] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic rand_image();
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  // Starts a frame, streams it, scoreboards every result against the model.
  task automatic run_frame(input string nm, input int w, input int h, input int sh,
                           input bit relu, input bit pool, input int stall_at,
                           input bit full_rate, input bit poke, output int cyc);
    int n, pix, viol, hviol, stall_left;
    bit stalled, done_seen, hold_pend;
    logic [15:0] hd;
    logic hl;
    n = w * h;
    build_model(w, h, sh, relu, pool);
    got_d.delete();
    got_l.delete();
    @(negedge clk);
    cfg_width_i = 5'(w); cfg_height_i = 16'(h); cfg_shift_i = 5'(sh);
    cfg_relu_en_i = relu; cfg_pool_en_i = pool; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pix = 0; viol = 0; hviol = 0; stall_left = 0; stalled = 0; done_seen = 0;
    hold_pend = 0; hd = '0; hl = 1'b0; cyc = 0;
    while (cyc < 20000) begin
      if (done_o) begin
        done_seen = 1;
        break;
      end
      in_valid_i = (pix < n) && (full_rate || ($urandom_range(0, 3) != 0));
      in_data_i  = (pix < n) ? 8'(img[pix]) : 8'h00;
      if (stall_at >= 0 && got_d.size() == stall_at && !stalled) begin
        stall_left = 5;
        stalled    = 1;
      end
      out_ready_i = (stall_left > 0) ? 1'b0 : (full_rate || ($urandom_range(0, 2) != 0));
      if (stall_left > 0) stall_left--;
      wt_we_i = poke && (cyc == 0);
      wt_ch_i = 1'b0; wt_idx_i = 4'd4; wt_data_i = 8'd77;
      cfg_width_i = 5'($urandom); cfg_height_i = 16'($urandom); cfg_shift_i = 5'($urandom);
      cfg_relu_en_i = 1'($urandom); cfg_pool_en_i = 1'($urandom);
      #1;
      if (out_valid_o && !out_ready_i && in_ready_o) viol++;
      if (hold_pend && out_valid_o && (out_data_o !== hd || out_last_o !== hl)) hviol++;
      hold_pend = out_valid_o && !out_ready_i;
      hd = out_data_o;
      hl = out_last_o;
      if (in_valid_i && in_ready_o) pix++;
      if (out_valid_o && out_ready_i) begin
        got_d.push_back(out_data_o);
        got_l.push_back(out_last_o);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_i = 1'b0; wt_we_i = 1'b0; out_ready_i = 1'b0;
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL %s done: done_o seen=%0d required 1 within %0d cycles", nm, done_seen, cyc);
    end
    n_cmp++;
    if (got_d.size() !== exp_d.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d results, required %0d", nm, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        n_bad++;
        $display("FAIL %s result[%0d]: got data=%h last=%0d, required data=%h last=%0d",
                 nm, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (viol !== 0) begin
      n_bad++;
      $display("FAIL %s backpressure: in_ready_o high during %0d stalled cycles, required 0", nm, viol);
    end
    n_cmp++;
    if (hviol !== 0) begin
      n_bad++;
      $display("FAIL %s hold: output changed in %0d stalled cycles, required 0", nm, hviol);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s post_done: busy=%b done=%b, required 0 0", nm, busy_o, done_o);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy_o, done_o, err_o, out_valid_o, in_ready_o, out_last_o, out_data_o} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b err=%b ov=%b ir=%b last=%b data=%h, required all 0",
               busy_o, done_o, err_o, out_valid_o, in_ready_o, out_last_o, out_data_o);
    end
  endtask

  task automatic test_identity();
    int cyc;
    int e0 [4] = '{5, 6, 9, 10};
    logic [15:0] g;
    for (int ch = 0; ch < 2; ch++) for (int t = 0; t < 9; t++) wts[ch][t] = 0;
    wts[0][4] = 1;
    wts[1][4] = -1;
    load_weights();
    @(negedge clk);
    wt_we_i = 1'b1; wt_ch_i = 1'b0; wt_idx_i = 4'd12; wt_data_i = 8'h55;
    @(negedge clk);
    wt_we_i = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = i;
    run_frame("identity", 4, 4, 0, 0, 0, -1, 0, 0, cyc);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      g = got_d[i];
      n_cmp++;
      if (g[7:0] !== 8'(e0[i]) || g[15:8] !== 8'(-e0[i]) || got_l[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL identity_const[%0d]: got ch0=%0d ch1=%0d last=%0d, required %0d %0d %0d",
                 i, $signed(g[7:0]), $signed(g[15:8]), got_l[i], e0[i], -e0[i], (i == 3));
      end
    end
  endtask

  task automatic test_relu_pool();
    int cyc;
    logic [15:0] g;
    run_frame("relu", 4, 4, 0, 1, 0, -1, 0, 0, cyc);
    for (int i = 0; i < got_d.size(); i++) begin
      g = got_d[i];
      n_cmp++;
      if (g[15:8] !== 8'd0) begin
        n_bad++;
        $display("FAIL relu_ch1[%0d]: got %0d, required 0", i, $signed(g[15:8]));
      end
    end
    run_frame("pool4", 4, 4, 0, 0, 1, -1, 0, 0, cyc);
    g = (got_d.size() > 0) ? got_d[0] : 16'hxxxx;
    n_cmp++;
    if (got_d.size() !== 1 || g[7:0] !== 8'd10 || got_l[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL pool4_const: got n=%0d ch0=%h, required n=1 ch0=0a last=1", got_d.size(), g[7:0]);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    int wv [3] = '{127, -128, 127};
    int sv [3] = '{0, 0, 16};
    int ev [3] = '{127, -128, 4};
    for (int i = 0; i < 9; i++) img[i] = 255;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 2; ch++) for (int t = 0; t < 9; t++) wts[ch][t] = wv[k];
      load_weights();
      run_frame("saturate", 3, 3, sv[k], 0, 0, -1, 0, 0, cyc);
      n_cmp++;
      if (got_d.size() !== 1 || got_d[0] !== {8'(ev[k]), 8'(ev[k])}) begin
        n_bad++;
        $display("FAIL saturate_const[%0d]: got n=%0d data=%h, required one result of %0d per channel",
                 k, got_d.size(), (got_d.size() > 0) ? got_d[0] : 16'hxxxx, ev[k]);
      end
    end
  endtask

  task automatic test_pool_5x5();
    int cyc;
    rand_weights();
    load_weights();
    rand_image();
    run_frame("pool5", 5, 5, 2, 0, 1, -1, 0, 0, cyc);
    n_cmp++;
    if (got_d.size() !== 1) begin
      n_bad++;
      $display("FAIL pool5_count: got %0d, required 1", got_d.size());
    end
  endtask

  task automatic test_random();
    int cyc, w, h;
    bit pool;
    for (int f = 0; f < 4; f++) begin
      rand_weights();
      load_weights();
      rand_image();
      w = int'($urandom_range(3, 28));
      h = int'($urandom_range(3, 10));
      pool = 1'($urandom);
      if (pool && w < 4) w = 4;
      if (pool && h < 4) h = 4;
      run_frame("random", w, h, int'($urandom_range(0, 10)), 1'($urandom), pool, -1, 0, 0, cyc);
    end
  endtask

  task automatic test_stall();
    int cyc;
    rand_weights();
    load_weights();
    rand_image();
    run_frame("stall28", 28, 28, 7, 0, 0, 100, 1, 0, cyc);
    n_cmp++;
    if (got_d.size() !== 676) begin
      n_bad++;
      $display("FAIL stall28_count: got %0d, required 676", got_d.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    rand_image();
    run_frame("b2b", 28, 28, 5, 1, 1, -1, 1, 0, cyc);
    n_cmp++;
    if (cyc > 784 + 3) begin
      n_bad++;
      $display("FAIL b2b_throughput: got %0d cycles, required at most %0d", cyc, 784 + 3);
    end
  endtask

  task automatic test_errors();
    int ew [4] = '{2, 29, 4, 5};
    int eh [4] = '{4, 4, 3, 2};
    bit ep [4] = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cfg_width_i = 5'(ew[k]); cfg_height_i = 16'(eh[k]); cfg_pool_en_i = ep[k];
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n_cmp++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL err_start[%0d]: err=%b busy=%b, required 1 0", k, err_o, busy_o);
      end
      @(negedge clk);
      n_cmp++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL err_pulse[%0d]: err=%b busy=%b, required 0 0", k, err_o, busy_o);
      end
    end
  endtask

  task automatic test_wt_busy();
    int cyc;
    for (int ch = 0; ch < 2; ch++) for (int t = 0; t < 9; t++) wts[ch][t] = 0;
    wts[0][4] = 1;
    wts[1][0] = 3;
    load_weights();
    rand_image();
    run_frame("wt_busy", 6, 5, 0, 0, 0, -1, 0, 1, cyc);
    run_frame("wt_after", 4, 4, 0, 0, 0, -1, 0, 0, cyc);
  endtask

  task automatic test_reset_midframe();
    int cyc;
    rand_weights();
    load_weights();
    @(negedge clk);
    cfg_width_i = 5'd8; cfg_height_i = 16'd8; cfg_shift_i = 5'd0;
    cfg_relu_en_i = 1'b0; cfg_pool_en_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'($urandom);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: busy=%b ov=%b done=%b, required 0 0 0", busy_o, out_valid_o, done_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int ch = 0; ch < 2; ch++) for (int t = 0; t < 9; t++) wts[ch][t] = 0;
    rand_image();
    run_frame("after_reset_zero_wt", 5, 4, 0, 0, 0, -1, 0, 0, cyc);
    rand_weights();
    load_weights();
    run_frame("after_reset", 6, 6, 3, 0, 0, -1, 0, 0, cyc);
  endtask

  initial begin
    rst_ni = 1'b0;
    cfg_width_i = '0; cfg_height_i = '0; cfg_shift_i = '0;
    cfg_relu_en_i = 1'b0; cfg_pool_en_i = 1'b0; start_i = 1'b0;
    wt_we_i = 1'b0; wt_ch_i = '0; wt_idx_i = '0; wt_data_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk);
    test_reset();
    test_identity();
    test_relu_pool();
    test_saturation();
    test_pool_5x5();
    test_random();
    test_stall();
    test_back_to_back();
    test_errors();
    test_wt_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
